// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
// Free-running raster source for the dimming pipeline. It produces a pixel
// stream (DE, HSYNC, VSYNC, 24-bit RGB) in the ODCK domain, with a choice of
// test patterns. The pattern and the solid colour are captured once per frame,
// so a frame is never torn by a mid-frame change.
//
// Ports
//   iODCK        in   pixel clock
//   iRST         in   synchronous active-high reset
//   iEn          in   run enable (a frame in progress always completes)
//   iPattern[1:0] in  0 solid, 1 gray ramp, 2 checkerboard, 3 colour bars
//   iColor[23:0] in   solid colour {R,G,B}
//   oDE          out  data enable
//   oHSYNC       out  horizontal sync, active level SYNC_POL
//   oVSYNC       out  vertical sync, active level SYNC_POL
//   oQE[23:0]    out  pixel {R,G,B}, zero outside the active area
//   oFrameStart  out  one-cycle pulse with the first pixel of each frame
//   oFrameCount  out  frames started since reset, wraps 255 -> 0
// All outputs are registered and show raster position (h,v) one clock later.
// -----------------------------------------------------------------------------
module video_timing_gen #(
   parameter int H_ACTIVE = 1920,
   parameter int H_FP     = 88,
   parameter int H_SYNC   = 44,
   parameter int H_BP     = 148,
   parameter int V_ACTIVE = 1080,
   parameter int V_FP     = 4,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 36,
   parameter int SYNC_POL = 1,
   parameter int BLK_LOG2 = 6
) (
   input  logic        iODCK,
   input  logic        iRST,
   input  logic        iEn,
   input  logic [1:0]  iPattern,
   input  logic [23:0] iColor,
   output logic        oDE,
   output logic        oHSYNC,
   output logic        oVSYNC,
   output logic [23:0] oQE,
   output logic        oFrameStart,
   output logic [7:0]  oFrameCount
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [11:0] H_ACT_C  = 12'(H_ACTIVE);
   localparam logic [11:0] V_ACT_C  = 12'(V_ACTIVE);
   localparam logic [11:0] HS_BEG_C = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_END_C = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] VS_BEG_C = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] VS_END_C = 12'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [11:0] H_LAST_C = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST_C = 12'(V_TOTAL - 1);

   localparam logic SYNC_ON  = (SYNC_POL != 0);
   localparam logic SYNC_OFF = ~SYNC_ON;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [11:0] h_q, h_d;
   logic [11:0] v_q, v_d;
   logic [1:0]  pat_q, pat_d;
   logic [23:0] col_q, col_d;
   logic        de_q, de_d;
   logic        hs_q, hs_d;
   logic        vs_q, vs_d;
   logic [23:0] qe_q, qe_d;
   logic        fs_q, fs_d;
   logic [7:0]  fc_q, fc_d;

   logic        first_w;
   logic        act_w;

   assign first_w = (h_q == 12'd0) && (v_q == 12'd0);
   assign act_w   = (h_q < H_ACT_C) && (v_q < V_ACT_C);

   // Bar boundaries i*H_ACTIVE/8 are elaboration-time constants.
   function automatic logic [2:0] bar_index(input logic [11:0] h);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (h >= 12'(i * H_ACTIVE / 8)) idx = 3'(i);
      end
      return idx;
   endfunction

   function automatic logic [23:0] bar_color(input logic [2:0] idx);
      logic [23:0] c;
      unique case (idx)
         3'd0:    c = 24'hFFFFFF;
         3'd1:    c = 24'hFFFF00;
         3'd2:    c = 24'h00FFFF;
         3'd3:    c = 24'h00FF00;
         3'd4:    c = 24'hFF00FF;
         3'd5:    c = 24'hFF0000;
         3'd6:    c = 24'h0000FF;
         default: c = 24'h000000;
      endcase
      return c;
   endfunction

   function automatic logic [23:0] pixel(input logic [1:0]  pat,
                                         input logic [23:0] col,
                                         input logic [11:0] h,
                                         input logic [11:0] v);
      logic [23:0] p;
      unique case (pat)
         2'd0:    p = col;
         2'd1:    p = {h[10:3], h[10:3], h[10:3]};
         2'd2:    p = (h[BLK_LOG2] ^ v[BLK_LOG2]) ? 24'hFFFFFF : 24'h000000;
         default: p = bar_color(bar_index(h));
      endcase
      return p;
   endfunction

   always_comb begin
      state_d = state_q;
      h_d     = h_q;
      v_d     = v_q;
      pat_d   = pat_q;
      col_d   = col_q;
      de_d    = 1'b0;
      hs_d    = SYNC_OFF;
      vs_d    = SYNC_OFF;
      qe_d    = 24'h000000;
      fs_d    = 1'b0;
      fc_d    = fc_q;
      unique case (state_q)
         IDLE: begin
            h_d = 12'd0;
            v_d = 12'd0;
            if (iEn) state_d = RUN;
         end
         default: begin
            // The shadow is loaded at (0,0) and that pixel already uses the
            // newly captured values.
            if (first_w) begin
               pat_d = iPattern;
               col_d = iColor;
               fs_d  = 1'b1;
               fc_d  = fc_q + 8'd1;
            end
            de_d = act_w;
            hs_d = (h_q >= HS_BEG_C && h_q < HS_END_C) ? SYNC_ON : SYNC_OFF;
            vs_d = (v_q >= VS_BEG_C && v_q < VS_END_C) ? SYNC_ON : SYNC_OFF;
            if (act_w) qe_d = pixel(pat_d, col_d, h_q, v_q);
            if (h_q == H_LAST_C) begin
               h_d = 12'd0;
               if (v_q == V_LAST_C) begin
                  v_d = 12'd0;
                  if (!iEn) state_d = IDLE;
               end else begin
                  v_d = v_q + 12'd1;
               end
            end else begin
               h_d = h_q + 12'd1;
            end
         end
      endcase
   end

   always_ff @(posedge iODCK) begin
      if (iRST) begin
         state_q <= IDLE;
         h_q     <= 12'd0;
         v_q     <= 12'd0;
         pat_q   <= 2'd0;
         col_q   <= 24'h000000;
         de_q    <= 1'b0;
         hs_q    <= SYNC_OFF;
         vs_q    <= SYNC_OFF;
         qe_q    <= 24'h000000;
         fs_q    <= 1'b0;
         fc_q    <= 8'd0;
      end else begin
         state_q <= state_d;
         h_q     <= h_d;
         v_q     <= v_d;
         pat_q   <= pat_d;
         col_q   <= col_d;
         de_q    <= de_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         qe_q    <= qe_d;
         fs_q    <= fs_d;
         fc_q    <= fc_d;
      end
   end

   assign oDE         = de_q;
   assign oHSYNC      = hs_q;
   assign oVSYNC      = vs_q;
   assign oQE         = qe_q;
   assign oFrameStart = fs_q;
   assign oFrameCount = fc_q;

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

   localparam int HA = 16, HF = 2, HS = 2, HB = 2;
   localparam int VA = 8,  VF = 1, VS = 1, VB = 1;
   localparam int HT = HA + HF + HS + HB;   // 22
   localparam int VT = VA + VF + VS + VB;   // 11
   localparam int FRAME = HT * VT;          // 242

   logic        iODCK = 1'b0;
   logic        iRST, iEn;
   logic [1:0]  iPattern;
   logic [23:0] iColor;
   logic        oDE, oHSYNC, oVSYNC, oFrameStart;
   logic [23:0] oQE;
   logic [7:0]  oFrameCount;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   video_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .SYNC_POL(1), .BLK_LOG2(2)
   ) dut (
      .iODCK(iODCK), .iRST(iRST), .iEn(iEn), .iPattern(iPattern), .iColor(iColor),
      .oDE(oDE), .oHSYNC(oHSYNC), .oVSYNC(oVSYNC), .oQE(oQE),
      .oFrameStart(oFrameStart), .oFrameCount(oFrameCount)
   );

   always #5 iODCK = ~iODCK;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h at %0t", nm, act, want, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Position is a linear pixel index within the frame; h/v derived by div/mod.
   bit          m_run = 1'b0;
   int          m_n   = 0;
   int          m_pat = 0;
   logic [23:0] m_col = '0;
   int          m_fc  = 0;
   logic        e_de, e_hs, e_vs, e_fs;
   logic [23:0] e_qe;
   logic [7:0]  e_fc;

   function automatic logic [23:0] model_pix(input int pat, input logic [23:0] col,
                                             input int h, input int v);
      logic [23:0] bars [8];
      bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
      case (pat)
         0:       return col;
         1:       begin int g; g = (h / 8) % 256; return 24'(g * 24'h010101); end
         2:       return (((h / 4) + (v / 4)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
         default: return bars[(h * 8) / HA];
      endcase
   endfunction

   always @(posedge iODCK) begin
      e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_qe = '0; e_fs = 1'b0;
      if (iRST) begin
         m_run = 1'b0; m_n = 0; m_fc = 0;
      end else if (!m_run) begin
         if (iEn) begin m_run = 1'b1; m_n = 0; end
      end else begin
         int h, v;
         h = m_n % HT;
         v = m_n / HT;
         if (m_n == 0) begin
            m_pat = int'(iPattern); m_col = iColor; e_fs = 1'b1; m_fc = (m_fc + 1) % 256;
         end
         e_de = (h < HA) && (v < VA);
         e_hs = (h >= HA + HF) && (h < HA + HF + HS);
         e_vs = (v >= VA + VF) && (v < VA + VF + VS);
         if (e_de) e_qe = model_pix(m_pat, m_col, h, v);
         m_n++;
         if (m_n == FRAME) begin
            m_n = 0;
            if (!iEn) m_run = 1'b0;
         end
      end
      e_fc = 8'(m_fc);
   end

   always @(negedge iODCK) begin
      if (chk_en) begin
         check("m_de", 32'(oDE), 32'(e_de));
         check("m_hsync", 32'(oHSYNC), 32'(e_hs));
         check("m_vsync", 32'(oVSYNC), 32'(e_vs));
         check("m_qe", 32'(oQE), 32'(e_qe));
         check("m_fs", 32'(oFrameStart), 32'(e_fs));
         check("m_fc", 32'(oFrameCount), 32'(e_fc));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step(input int n);
      repeat (n) @(negedge iODCK);
   endtask

   task automatic wait_fs(input string nm);
      int k;
      k = 0;
      do begin
         @(negedge iODCK);
         k++;
      end while (!oFrameStart && k < 600);
      check(nm, 32'(oFrameStart), 32'd1);
   endtask

   initial begin
      int de_cnt, hs_first, vs_first, vs_cnt, fs_cnt, fc_before, k;
      iRST = 1'b1; iEn = 1'b0; iPattern = 2'd0; iColor = 24'h000000;
      @(posedge iODCK);
      #1 chk_en = 1'b1;
      step(2);
      check("rst_de", 32'(oDE), 32'd0);
      check("rst_hs", 32'(oHSYNC), 32'd0);
      check("rst_vs", 32'(oVSYNC), 32'd0);
      check("rst_qe", 32'(oQE), 32'd0);
      check("rst_fc", 32'(oFrameCount), 32'd0);

      // 1+2: solid colour run, measure one full frame
      iColor = 24'h123456; iRST = 1'b0; iEn = 1'b1;
      wait_fs("fs_first");
      check("fc_first", 32'(oFrameCount), 32'd1);
      check("qe_first", 32'(oQE), 32'h123456);
      de_cnt = 0; hs_first = -1; vs_first = -1; vs_cnt = 0;
      for (int i = 0; i < FRAME; i++) begin
         if (i > 0) @(negedge iODCK);
         de_cnt += int'(oDE);
         if (oHSYNC && hs_first < 0) hs_first = i;
         if (oVSYNC) begin vs_cnt++; if (vs_first < 0) vs_first = i; end
      end
      check("de_per_frame", 32'(de_cnt), 32'd128);
      check("hs_offset", 32'(hs_first), 32'd18);
      check("vs_offset", 32'(vs_first), 32'd198);
      check("vs_len", 32'(vs_cnt), 32'd22);
      step(1);
      check("fs_period", 32'(oFrameStart), 32'd1);

      // 3: checkerboard, gray ramp, bars
      iPattern = 2'd2;
      wait_fs("fs_chk");
      check("chk_h0v0", 32'(oQE), 32'h000000);
      step(4);
      check("chk_h4v0", 32'(oQE), 32'hFFFFFF);
      step(88);
      check("chk_h4v4", 32'(oQE), 32'h000000);
      iPattern = 2'd1;
      wait_fs("fs_gray");
      step(7);
      check("gray_h7", 32'(oQE), 32'h000000);
      step(1);
      check("gray_h8", 32'(oQE), 32'h010101);
      iPattern = 2'd3;
      wait_fs("fs_bars");
      check("bar_h0", 32'(oQE), 32'hFFFFFF);
      step(1);
      check("bar_h1", 32'(oQE), 32'hFFFFFF);
      step(1);
      check("bar_h2", 32'(oQE), 32'hFFFF00);
      step(12);
      check("bar_h14", 32'(oQE), 32'h000000);
      step(1);
      check("bar_h15", 32'(oQE), 32'h000000);

      // 4: pattern change mid-frame takes effect only at next frame
      iPattern = 2'd0;
      wait_fs("fs_solid");
      step(66);
      iPattern = 2'd3;
      step(4);
      check("hold_h4v3", 32'(oQE), 32'h123456);
      wait_fs("fs_switch");
      check("switch_h0", 32'(oQE), 32'hFFFFFF);

      // 5: enable dropped at line 2 finishes the frame, then idles
      step(44);
      iEn = 1'b0;
      fc_before = int'(oFrameCount);
      de_cnt = 0; fs_cnt = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge iODCK);
         de_cnt += int'(oDE);
         fs_cnt += int'(oFrameStart);
      end
      check("tail_de", 32'(de_cnt), 32'd95);
      check("idle_fs", 32'(fs_cnt), 32'd0);
      check("idle_fc", 32'(oFrameCount), 32'(fc_before));
      iEn = 1'b1;
      k = 0;
      do begin
         @(negedge iODCK);
         k++;
      end while (!oDE && k < 50);
      check("restart_lat", 32'(k), 32'd2);
      check("restart_fc", 32'(oFrameCount), 32'((fc_before + 1) % 256));

      // 6: reset mid-active aborts immediately
      step(30);
      iRST = 1'b1;
      step(1);
      check("mrst_de", 32'(oDE), 32'd0);
      check("mrst_qe", 32'(oQE), 32'd0);
      check("mrst_hs", 32'(oHSYNC), 32'd0);
      check("mrst_vs", 32'(oVSYNC), 32'd0);
      check("mrst_fc", 32'(oFrameCount), 32'd0);
      iRST = 1'b0;
      wait_fs("fs_after_rst");
      check("fc_after_rst", 32'(oFrameCount), 32'd1);
      check("qe_after_rst", 32'(oQE), 32'hFFFFFF);
      step(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
